eth_frame_gen: RTL and testbench

//  Synthesizable Ethernet frame source for the UDP/IP stack benches and loopback designs.

---
 rtl/eth_frame_gen_pkg.sv | 29 ++
 rtl/eth_frame_gen_buf.sv | 27 ++
 rtl/eth_frame_gen.sv | 193 +++++++++++++++++++
 tb/tb_eth_frame_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_gen_pkg.sv
// Shared types and helpers for the Ethernet frame source.
// Error injection is enabled by defining ETH_FRAME_GEN_ERR_INJECT_EN.
package eth_frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam int          KEEP_MAX      = 128;

  // Byte enables of the final beat; a zero remainder means a full word.
  function automatic logic [KEEP_MAX-1:0] last_keep(
    input int unsigned len,
    input int unsigned kw
  );
    int unsigned          rem;
    logic [KEEP_MAX-1:0]  k;
    rem = len % kw;
    k   = '1;
    if (rem != 0)
      k = (KEEP_MAX'(1) << rem) - KEEP_MAX'(1);
    return k;
  endfunction

endpackage

// File: rtl/eth_frame_gen_buf.sv
// Payload word buffer: simple dual-port RAM, 1-cycle sync read.
// Read returns the old word on a same-address write (read-first).
module eth_frame_gen_buf
  import eth_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet frame source: header on valid/ready, payload as AXI-stream.
// Define ETH_FRAME_GEN_ERR_INJECT_EN to drive tuser from s_desc_err.
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int BUF_DEPTH  = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         buf_wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] buf_wr_addr,
  input  logic [DATA_WIDTH-1:0]        buf_wr_data,
  input  logic                         s_desc_valid,
  output logic                         s_desc_ready,
  input  logic [47:0]                  s_desc_dest_mac,
  input  logic [47:0]                  s_desc_src_mac,
  input  logic [15:0]                  s_desc_type,
  input  logic [$clog2(BUF_DEPTH)-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]         s_desc_len,
  input  logic                         s_desc_err,
  output logic                         m_eth_hdr_valid,
  input  logic                         m_eth_hdr_ready,
  output logic [47:0]                  m_eth_dest_mac,
  output logic [47:0]                  m_eth_src_mac,
  output logic [15:0]                  m_eth_type,
  output logic [DATA_WIDTH-1:0]        m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_eth_payload_axis_tkeep,
  output logic                         m_eth_payload_axis_tvalid,
  input  logic                         m_eth_payload_axis_tready,
  output logic                         m_eth_payload_axis_tlast,
  output logic                         m_eth_payload_axis_tuser,
  output logic                         busy,
  output logic                         desc_error,
  output logic [31:0]                  frame_count
);

  localparam int AW = $clog2(BUF_DEPTH);

  state_t                state, state_nx;
  logic                  desc_fire, desc_go, hdr_fire, pay_fire;
  logic                  load_ok, out_free, load_out;
  logic                  rd_en, rd_pend, pend_last;
  logic                  sk_valid, sk_next, sk_last;
  logic                  ram_to_out, ram_to_sk, src_last;
  logic [AW-1:0]         rd_ptr, rd_addr;
  logic [LEN_WIDTH-1:0]  rd_cnt;
  logic [DATA_WIDTH-1:0] ram_q, sk_data, src_data;
  logic [KEEP_WIDTH-1:0] keep_last;
  logic [31:0]           beats;

  eth_frame_gen_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_wr_en),
    .wr_addr(buf_wr_addr),
    .wr_data(buf_wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

  assign s_desc_ready    = (state == IDLE);
  assign m_eth_hdr_valid = (state == HDR);
  assign busy            = (state != IDLE);

  assign desc_fire = s_desc_valid && s_desc_ready;
  assign desc_go   = desc_fire && (s_desc_len != '0);
  assign hdr_fire  = m_eth_hdr_valid && m_eth_hdr_ready;
  assign pay_fire  = m_eth_payload_axis_tvalid
                  && m_eth_payload_axis_tready;

  assign beats = (32'(s_desc_len) + 32'(KEEP_WIDTH - 1))
               / 32'(KEEP_WIDTH);

  // Output reg may only load once the header has gone (or is going) out.
  assign load_ok  = (state == PAYLOAD) || hdr_fire;
  assign out_free = load_ok
                 && (!m_eth_payload_axis_tvalid
                     || m_eth_payload_axis_tready);
  assign load_out = out_free && (sk_valid || rd_pend);
  assign src_data = sk_valid ? sk_data : ram_q;
  assign src_last = sk_valid ? sk_last : pend_last;

  assign ram_to_out = out_free && !sk_valid && rd_pend;
  assign ram_to_sk  = rd_pend && !ram_to_out;
  assign sk_next    = out_free ? (sk_valid && rd_pend)
                               : (sk_valid || rd_pend);

  // A read is issued only when its data is sure to find a free slot.
  assign rd_en   = desc_go
                || ((state != IDLE) && (rd_cnt != '0) && !sk_next);
  assign rd_addr = (state == IDLE) ? s_desc_addr : rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (desc_go)  state_nx = HDR;
      HDR:     if (hdr_fire) state_nx = PAYLOAD;
      PAYLOAD:
        if (pay_fire && m_eth_payload_axis_tlast)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_error                <= 1'b0;
      m_eth_dest_mac            <= '0;
      m_eth_src_mac             <= '0;
      m_eth_type                <= '0;
      keep_last                 <= '0;
      rd_ptr                    <= '0;
      rd_cnt                    <= '0;
      rd_pend                   <= 1'b0;
      pend_last                 <= 1'b0;
      sk_valid                  <= 1'b0;
      sk_data                   <= '0;
      sk_last                   <= 1'b0;
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tdata  <= '0;
      m_eth_payload_axis_tkeep  <= '0;
      m_eth_payload_axis_tlast  <= 1'b0;
      frame_count               <= '0;
    end else begin
      desc_error <= desc_fire && (s_desc_len == '0);
      if (desc_fire) begin
        m_eth_dest_mac <= s_desc_dest_mac;
        m_eth_src_mac  <= s_desc_src_mac;
        m_eth_type     <= s_desc_type;
        keep_last      <= KEEP_WIDTH'(last_keep(
                            32'(s_desc_len), KEEP_WIDTH));
      end
      if (desc_go) begin
        rd_ptr <= s_desc_addr + 1'b1;
        rd_cnt <= LEN_WIDTH'(beats - 32'd1);
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt - 1'b1;
      end
      rd_pend   <= rd_en;
      pend_last <= desc_go ? (beats == 32'd1)
                           : (rd_cnt == LEN_WIDTH'(1));
      sk_valid  <= sk_next;
      if (ram_to_sk) begin
        sk_data <= ram_q;
        sk_last <= pend_last;
      end
      if (out_free)
        m_eth_payload_axis_tvalid <= sk_valid || rd_pend;
      if (load_out) begin
        m_eth_payload_axis_tdata <= src_data;
        m_eth_payload_axis_tlast <= src_last;
        m_eth_payload_axis_tkeep <= src_last ? keep_last : '1;
      end
      if (pay_fire && m_eth_payload_axis_tlast)
        frame_count <= frame_count + 32'd1;
    end
  end

`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q                    <= 1'b0;
      m_eth_payload_axis_tuser <= 1'b0;
    end else begin
      if (desc_fire)
        err_q <= s_desc_err;
      if (load_out)
        m_eth_payload_axis_tuser <= err_q && src_last;
    end
  end
`else
  logic unused_err;
  assign unused_err               = s_desc_err;
  assign m_eth_payload_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: vector table, reset/error sequences, random frames.
// Define ETH_FRAME_GEN_ERR_INJECT_EN to expect tuser on errored frames.
module tb_eth_frame_gen;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 256;
  localparam int LW    = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          s_desc_valid, s_desc_ready;
  logic [47:0]   s_desc_dest_mac, s_desc_src_mac;
  logic [15:0]   s_desc_type;
  logic [AW-1:0] s_desc_addr;
  logic [LW-1:0] s_desc_len;
  logic          s_desc_err;
  logic          hdr_valid, hdr_ready;
  logic [47:0]   dest_mac, src_mac;
  logic [15:0]   eth_type;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tready, tlast, tuser;
  logic          busy, desc_error;
  logic [31:0]   frame_count;

  always #5 clk = ~clk;

  eth_frame_gen #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .BUF_DEPTH (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .buf_wr_en                (buf_wr_en),
    .buf_wr_addr              (buf_wr_addr),
    .buf_wr_data              (buf_wr_data),
    .s_desc_valid             (s_desc_valid),
    .s_desc_ready             (s_desc_ready),
    .s_desc_dest_mac          (s_desc_dest_mac),
    .s_desc_src_mac           (s_desc_src_mac),
    .s_desc_type              (s_desc_type),
    .s_desc_addr              (s_desc_addr),
    .s_desc_len               (s_desc_len),
    .s_desc_err               (s_desc_err),
    .m_eth_hdr_valid          (hdr_valid),
    .m_eth_hdr_ready          (hdr_ready),
    .m_eth_dest_mac           (dest_mac),
    .m_eth_src_mac            (src_mac),
    .m_eth_type               (eth_type),
    .m_eth_payload_axis_tdata (tdata),
    .m_eth_payload_axis_tkeep (tkeep),
    .m_eth_payload_axis_tvalid(tvalid),
    .m_eth_payload_axis_tready(tready),
    .m_eth_payload_axis_tlast (tlast),
    .m_eth_payload_axis_tuser (tuser),
    .busy                     (busy),
    .desc_error               (desc_error),
    .frame_count              (frame_count)
  );

  typedef struct {
    int         len;
    int         addr;
    bit         err;
    int         hdr_dly;
    int         mode;
    int         exp_beats;
    logic [7:0] exp_lkeep;
  } vec_t;

  logic [DW-1:0] mem_m [DEPTH];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            exp_fc = 0;
  vec_t          tbl [7];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic int model_beats(input int len);
    int b    = 0;
    int left = len;
    while (left > 0) begin
      b++;
      left -= KW;
    end
    return b;
  endfunction

  function automatic logic [7:0] model_keep(input int len, input int idx);
    int         bytes = len - idx * KW;
    logic [7:0] k     = '0;
    for (int j = 0; j < KW; j++)
      if (j < bytes) k[j] = 1'b1;
    return k;
  endfunction

  task automatic run_frame(input vec_t v,
                           input logic [47:0] dm,
                           input logic [47:0] sm,
                           input logic [15:0] ty);
    int            nb    = model_beats(v.len);
    int            seen  = 0;
    bit            done  = 0;
    bit            stall = 0;
    bit            tr    = 0;
    bit            exp_tu;
    logic [7:0]    lk    = '0;
    logic [DW-1:0] sd;
    logic [KW-1:0] skp;
    logic          sl;
    @(negedge clk);
    chk("desc_ready", s_desc_ready, 1);
    s_desc_valid    = 1;
    s_desc_dest_mac = dm;
    s_desc_src_mac  = sm;
    s_desc_type     = ty;
    s_desc_addr     = AW'(v.addr);
    s_desc_len      = LW'(v.len);
    s_desc_err      = v.err;
    @(negedge clk);
    s_desc_valid = 0;
    chk("hdr_valid_rise", hdr_valid, 1);
    chk("hdr_dest", dest_mac, dm);
    chk("hdr_src", src_mac, sm);
    chk("hdr_type", eth_type, ty);
    repeat (v.hdr_dly) @(negedge clk);
    if (v.hdr_dly > 0)
      chk("hdr_hold", {hdr_valid, tvalid, dest_mac}, {2'b10, dm});
    hdr_ready = 1;
    @(negedge clk);
    hdr_ready = 0;
    chk("hdr_drop", hdr_valid, 0);
    chk("tvalid_rise", tvalid, 1);
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (stall) begin
        chk("stall_ctl", {tvalid, tlast, tkeep}, {1'b1, sl, skp});
        chk("stall_data", tdata, sd);
      end
      case (v.mode)
        0:       tr = 1;
        1:       if (tvalid) tr = !tr;
        default: tr = ($urandom_range(0, 3) != 0);
      endcase
      tready = tr;
      if (tvalid && tr) begin
`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
        exp_tu = v.err && (seen == nb - 1);
`else
        exp_tu = 0;
`endif
        chk("beat_data", tdata, mem_m[(v.addr + seen) % DEPTH]);
        chk("beat_keep", tkeep, model_keep(v.len, seen));
        chk("beat_last", tlast, seen == nb - 1);
        chk("beat_tuser", tuser, exp_tu);
        seen++;
        if (tlast) begin
          lk   = tkeep;
          done = 1;
        end
      end
      stall = tvalid && !tr;
      sd    = tdata;
      skp   = tkeep;
      sl    = tlast;
      @(negedge clk);
    end
    exp_fc++;
    chk("frame_done", done, 1);
    chk("beat_count", seen, v.exp_beats);
    chk("last_keep", lk, v.exp_lkeep);
    chk("tvalid_drop", tvalid, 0);
    chk("idle_state", {busy, s_desc_ready}, 2'b01);
    chk("frame_count", frame_count, exp_fc);
    tready = 0;
  endtask

  initial begin
    vec_t rv;
    rst             = 1;
    buf_wr_en       = 0;
    buf_wr_addr     = '0;
    buf_wr_data     = '0;
    s_desc_valid    = 0;
    s_desc_dest_mac = '0;
    s_desc_src_mac  = '0;
    s_desc_type     = '0;
    s_desc_addr     = '0;
    s_desc_len      = '0;
    s_desc_err      = 0;
    hdr_ready       = 0;
    tready          = 0;

    tbl[0] = '{28, 0, 0, 0, 0, 4, 8'h0F};
    tbl[1] = '{24, 8, 0, 0, 0, 3, 8'hFF};
    tbl[2] = '{40, 20, 0, 0, 1, 5, 8'hFF};
    tbl[3] = '{16, 255, 0, 0, 0, 2, 8'hFF};
    tbl[4] = '{12, 40, 1, 0, 0, 2, 8'h0F};
    tbl[5] = '{1, 60, 0, 2, 1, 1, 8'h01};
    tbl[6] = '{61, 250, 1, 3, 2, 8, 8'h1F};

    repeat (3) @(negedge clk);
    chk("rst_valids", {tvalid, hdr_valid, tlast, tuser}, 4'b0);
    chk("rst_flags", {busy, desc_error}, 2'b0);
    chk("rst_count", frame_count, 0);
    chk("rst_fields", {dest_mac, eth_type}, 64'h0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    rst = 0;
    @(negedge clk);
    chk("rel_ready", s_desc_ready, 1);

    for (int i = 0; i < DEPTH; i++) begin
      buf_wr_en   = 1;
      buf_wr_addr = AW'(i);
      buf_wr_data = {$urandom, $urandom};
      mem_m[i]    = buf_wr_data;
      @(negedge clk);
    end
    buf_wr_en = 0;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i], 48'hDAD1D2D3D4D5, 48'h5A5152535455,
                (i % 2 == 0) ? 16'h0800 : 16'h0806);

    // zero-length descriptor is rejected
    @(negedge clk);
    s_desc_valid = 1;
    s_desc_len   = '0;
    @(negedge clk);
    s_desc_valid = 0;
    chk("zero_err_pulse", desc_error, 1);
    chk("zero_no_hdr", {hdr_valid, busy}, 2'b00);
    @(negedge clk);
    chk("zero_err_clear", desc_error, 0);
    chk("zero_no_hdr2", hdr_valid, 0);
    chk("zero_count", frame_count, exp_fc);

    for (int i = 0; i < 20; i++) begin
      rv.len       = $urandom_range(1, 200);
      rv.addr      = $urandom_range(0, DEPTH - 1);
      rv.err       = $urandom_range(0, 1);
      rv.hdr_dly   = $urandom_range(0, 3);
      rv.mode      = $urandom_range(0, 2);
      rv.exp_beats = model_beats(rv.len);
      rv.exp_lkeep = model_keep(rv.len, rv.exp_beats - 1);
      run_frame(rv, {$urandom, 16'h0}, {16'h0, $urandom},
                16'($urandom));
    end

    // reset while beat 2 is on the bus
    @(negedge clk);
    s_desc_valid = 1;
    s_desc_addr  = 8'd0;
    s_desc_len   = 16'd40;
    @(negedge clk);
    s_desc_valid = 0;
    hdr_ready    = 1;
    @(negedge clk);
    hdr_ready = 0;
    tready    = 1;
    chk("mid_beat1", tvalid, 1);
    @(negedge clk);
    chk("mid_beat2", tdata, mem_m[1]);
    rst = 1;
    #1;
    chk("mid_rst_valids", {tvalid, hdr_valid, tlast, busy}, 4'b0);
    chk("mid_rst_count", frame_count, 0);
    @(negedge clk);
    chk("mid_rst_hold", {tvalid, hdr_valid}, 2'b0);
    rst    = 0;
    tready = 0;
    exp_fc = 0;
    @(negedge clk);
    chk("mid_rel_ready", s_desc_ready, 1);
    chk("mid_rel_count", frame_count, 0);
    run_frame(tbl[0], 48'h0102030405AA, 48'h0A0B0C0D0E0F, 16'h0806);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
